// File: rtl/axi_master_arbiter.sv
// rtl/axi_master_arbiter.sv - merges icache and dcache AXI3 masters onto one CPU master port
module axi_master_arbiter #(
  parameter logic [3:0] I_ID = 4'h0,
  parameter logic [3:0] D_ID = 4'h1
) (
  input  logic        aclk,
  input  logic        aresetn,
  // instruction cache read side
  input  logic [31:0] i_araddr,
  input  logic [3:0]  i_arlen,
  input  logic [2:0]  i_arsize,
  input  logic [1:0]  i_arburst,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic [1:0]  i_rresp,
  output logic        i_rlast,
  output logic        i_rvalid,
  input  logic        i_rready,
  // data cache read side
  input  logic [31:0] d_araddr,
  input  logic [3:0]  d_arlen,
  input  logic [2:0]  d_arsize,
  input  logic [1:0]  d_arburst,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic [1:0]  d_rresp,
  output logic        d_rlast,
  output logic        d_rvalid,
  input  logic        d_rready,
  // data cache write side
  input  logic [31:0] d_awaddr,
  input  logic [3:0]  d_awlen,
  input  logic [2:0]  d_awsize,
  input  logic [1:0]  d_awburst,
  input  logic        d_awvalid,
  output logic        d_awready,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  input  logic        d_wlast,
  input  logic        d_wvalid,
  output logic        d_wready,
  output logic [1:0]  d_bresp,
  output logic        d_bvalid,
  input  logic        d_bready,
  // merged master port
  output logic [3:0]  m_arid,
  output logic [31:0] m_araddr,
  output logic [3:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic [1:0]  m_arlock,
  output logic [3:0]  m_arcache,
  output logic [2:0]  m_arprot,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [3:0]  m_rid,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic [3:0]  m_awid,
  output logic [31:0] m_awaddr,
  output logic [3:0]  m_awlen,
  output logic [2:0]  m_awsize,
  output logic [1:0]  m_awburst,
  output logic [1:0]  m_awlock,
  output logic [3:0]  m_awcache,
  output logic [2:0]  m_awprot,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [3:0]  m_wid,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wlast,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [3:0]  m_bid,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready
);

  localparam logic [2:0] R_IDLE   = 3'd0;
  localparam logic [2:0] R_ADDR_I = 3'd1;
  localparam logic [2:0] R_ADDR_D = 3'd2;
  localparam logic [2:0] R_DATA_I = 3'd3;
  localparam logic [2:0] R_DATA_D = 3'd4;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [2:0] r_state_q, r_state_d;
  logic       last_grant_q, last_grant_d;  // 1: data cache was granted last
  logic [1:0] w_state_q, w_state_d;

  logic ar_sel_d, ar_open, ar_hs, r_to_i, r_to_d, r_done;
  logic w_idle, w_data, w_resp, aw_hs, w_hs;

  // Only one read is ever outstanding, so response IDs carry no routing information.
  logic unused_ids;
  assign unused_ids = ^{m_rid, m_bid};

  // Choose which master owns the AR channel; in R_IDLE the tie goes to whoever was not granted last.
  always_comb begin
    ar_sel_d = 1'b0;
    ar_open  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        ar_open  = 1'b1;
        ar_sel_d = d_arvalid & (~i_arvalid | ~last_grant_q);
      end
      R_ADDR_I: ar_open = 1'b1;
      R_ADDR_D: begin
        ar_open  = 1'b1;
        ar_sel_d = 1'b1;
      end
      R_DATA_D: ar_sel_d = 1'b1;
      default: ;
    endcase
  end

  assign m_arvalid = ar_open & (ar_sel_d ? d_arvalid : i_arvalid);
  assign m_araddr  = ar_sel_d ? d_araddr  : i_araddr;
  assign m_arlen   = ar_sel_d ? d_arlen   : i_arlen;
  assign m_arsize  = ar_sel_d ? d_arsize  : i_arsize;
  assign m_arburst = ar_sel_d ? d_arburst : i_arburst;
  assign m_arid    = ar_sel_d ? D_ID : I_ID;
  assign m_arlock  = 2'b00;
  assign m_arcache = 4'b0000;
  assign m_arprot  = 3'b000;
  assign i_arready = ar_open & ~ar_sel_d & i_arvalid & m_arready;
  assign d_arready = ar_open &  ar_sel_d & d_arvalid & m_arready;
  assign ar_hs     = m_arvalid & m_arready;

  assign r_to_i   = (r_state_q == R_DATA_I);
  assign r_to_d   = (r_state_q == R_DATA_D);
  assign i_rdata  = m_rdata;
  assign i_rresp  = m_rresp;
  assign i_rlast  = m_rlast;
  assign i_rvalid = r_to_i & m_rvalid;
  assign d_rdata  = m_rdata;
  assign d_rresp  = m_rresp;
  assign d_rlast  = m_rlast;
  assign d_rvalid = r_to_d & m_rvalid;
  assign m_rready = m_rvalid & ((r_to_i & i_rready) | (r_to_d & d_rready));
  assign r_done   = m_rvalid & m_rready & m_rlast;

  // Read FSM next state: lock the grant until AR handshake, then hold the R route until rlast.
  always_comb begin
    r_state_d    = r_state_q;
    last_grant_d = last_grant_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d    = ar_sel_d ? R_DATA_D : R_DATA_I;
          last_grant_d = ar_sel_d;
        end else if (i_arvalid | d_arvalid) begin
          r_state_d = ar_sel_d ? R_ADDR_D : R_ADDR_I;
        end
      end
      R_ADDR_I: if (ar_hs) begin
        r_state_d    = R_DATA_I;
        last_grant_d = 1'b0;
      end
      R_ADDR_D: if (ar_hs) begin
        r_state_d    = R_DATA_D;
        last_grant_d = 1'b1;
      end
      R_DATA_I, R_DATA_D: if (r_done) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  assign w_idle = (w_state_q == W_IDLE);
  assign w_data = (w_state_q == W_DATA);
  assign w_resp = (w_state_q == W_RESP);

  assign m_awid    = D_ID;
  assign m_awaddr  = d_awaddr;
  assign m_awlen   = d_awlen;
  assign m_awsize  = d_awsize;
  assign m_awburst = d_awburst;
  assign m_awlock  = 2'b00;
  assign m_awcache = 4'b0000;
  assign m_awprot  = 3'b000;
  assign m_awvalid = d_awvalid & w_idle;
  assign d_awready = m_awready & d_awvalid & w_idle;
  assign m_wid     = D_ID;
  assign m_wdata   = d_wdata;
  assign m_wstrb   = d_wstrb;
  assign m_wlast   = d_wlast;
  assign m_wvalid  = d_wvalid & (w_idle | w_data);
  assign d_wready  = m_wready & d_wvalid & (w_idle | w_data);
  assign d_bresp   = m_bresp;
  assign d_bvalid  = m_bvalid & w_resp;
  assign m_bready  = d_bready & m_bvalid & w_resp;
  assign aw_hs     = m_awvalid & m_awready;
  assign w_hs      = m_wvalid & m_wready;

  // Write FSM next state: one write in flight, from AW acceptance through the B response.
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE: if (aw_hs) w_state_d = (w_hs & d_wlast) ? W_RESP : W_DATA;
      W_DATA: if (w_hs & d_wlast) w_state_d = W_RESP;
      W_RESP: if (m_bvalid & m_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // State registers; reset leaves last_grant on the icache so the dcache wins the first tie.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q    <= R_IDLE;
      last_grant_q <= 1'b0;
      w_state_q    <= W_IDLE;
    end else begin
      r_state_q    <= r_state_d;
      last_grant_q <= last_grant_d;
      w_state_q    <= w_state_d;
    end
  end

endmodule

// File: tb/tb_axi_master_arbiter.sv
// tb/tb_axi_master_arbiter.sv - randomized directed bench for axi_master_arbiter
module tb_axi_master_arbiter;
  localparam logic [3:0] I_ID = 4'h0;
  localparam logic [3:0] D_ID = 4'h1;

  logic aclk, aresetn;
  logic [31:0] i_araddr, d_araddr, d_awaddr, d_wdata;
  logic [3:0]  i_arlen, d_arlen, d_awlen, d_wstrb;
  logic [2:0]  i_arsize, d_arsize, d_awsize;
  logic [1:0]  i_arburst, d_arburst, d_awburst;
  logic        i_arvalid, i_arready, d_arvalid, d_arready;
  logic [31:0] i_rdata, d_rdata;
  logic [1:0]  i_rresp, d_rresp, d_bresp;
  logic        i_rlast, i_rvalid, i_rready, d_rlast, d_rvalid, d_rready;
  logic        d_awvalid, d_awready, d_wlast, d_wvalid, d_wready, d_bvalid, d_bready;
  logic [3:0]  m_arid, m_arlen, m_arcache, m_rid, m_awid, m_awlen, m_awcache, m_wid, m_wstrb, m_bid;
  logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic [2:0]  m_arsize, m_arprot, m_awsize, m_awprot;
  logic [1:0]  m_arburst, m_arlock, m_rresp, m_awburst, m_awlock, m_bresp;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

  axi_master_arbiter #(.I_ID(I_ID), .D_ID(D_ID)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arburst(i_arburst),
    .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize), .d_arburst(d_arburst),
    .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rresp(d_rresp), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awsize(d_awsize), .d_awburst(d_awburst),
    .d_awvalid(d_awvalid), .d_awready(d_awready),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast), .d_wvalid(d_wvalid), .d_wready(d_wready),
    .d_bresp(d_bresp), .d_bvalid(d_bvalid), .d_bready(d_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pending requests per master (index 1 = dcache) and last grant.
  bit          pend[2];
  logic [31:0] pend_addr[2];
  logic [3:0]  pend_len[2];
  logic [2:0]  pend_size[2];
  bit          last_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  function automatic bit pick_d();
    if (pend[0] && pend[1]) return !last_d;
    return pend[1];
  endfunction

  task automatic clear_inputs();
    i_araddr = 0; i_arlen = 0; i_arsize = 0; i_arburst = 0; i_arvalid = 0; i_rready = 0;
    d_araddr = 0; d_arlen = 0; d_arsize = 0; d_arburst = 0; d_arvalid = 0; d_rready = 0;
    d_awaddr = 0; d_awlen = 0; d_awsize = 0; d_awburst = 0; d_awvalid = 0;
    d_wdata = 0; d_wstrb = 0; d_wlast = 0; d_wvalid = 0; d_bready = 0;
    m_arready = 0; m_rid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0; m_rvalid = 0;
    m_awready = 0; m_wready = 0; m_bid = 0; m_bresp = 0; m_bvalid = 0;
    pend[0] = 0; pend[1] = 0; last_d = 0;
  endtask

  task automatic req(input bit is_d, input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size);
    pend[is_d] = 1; pend_addr[is_d] = addr; pend_len[is_d] = len; pend_size[is_d] = size;
    if (is_d) begin
      d_araddr = addr; d_arlen = len; d_arsize = size; d_arburst = 2'b01; d_arvalid = 1;
    end else begin
      i_araddr = addr; i_arlen = len; i_arsize = size; i_arburst = 2'b01; i_arvalid = 1;
    end
  endtask

  // AR phase: slave ready after 'delay' cycles; optionally raise the other master at cycle raise_at.
  task automatic ar_phase(input int delay, input int raise_at, input logic [31:0] raise_addr, output bit w);
    w = pick_d();
    for (int c = 0; c <= delay; c++) begin
      if (c == raise_at) req(!w, raise_addr, 4'd7, 3'd2);
      m_arready = (c == delay);
      #1;
      chk("ar_valid", m_arvalid, 1);
      chk("ar_addr", m_araddr, pend_addr[w]);
      chk("ar_id", m_arid, w ? D_ID : I_ID);
      chk("ar_len", m_arlen, pend_len[w]);
      chk("ar_size", m_arsize, pend_size[w]);
      chk("ar_ready_winner", w ? d_arready : i_arready, c == delay);
      chk("ar_ready_loser", w ? i_arready : d_arready, 0);
      cyc();
    end
    m_arready = 0;
    pend[w] = 0;
    if (w) d_arvalid = 0; else i_arvalid = 0;
    last_d = w;
  endtask

  task automatic set_rready(input bit w, input logic v);
    if (w) d_rready = v; else i_rready = v;
  endtask

  // R beats routed to master w; burst is n_total long, n_run beats are driven here.
  task automatic r_beats(input bit w, input int n_total, input int n_run);
    logic [31:0] dat;
    logic [1:0]  rsp;
    for (int b = 0; b < n_run; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        m_rvalid = 0;
        #1;
        chk("r_gap_i", i_rvalid, 0);
        chk("r_gap_d", d_rvalid, 0);
        chk("r_gap_arvalid", m_arvalid, 0);
        cyc();
      end
      dat = $urandom; rsp = 2'($urandom_range(0, 3));
      m_rvalid = 1; m_rdata = dat; m_rresp = rsp; m_rlast = (b == n_total - 1);
      m_rid = w ? D_ID : I_ID;
      if ($urandom_range(0, 3) == 0) begin
        set_rready(w, 0);
        #1;
        chk("r_stall_rready", m_rready, 0);
        chk("r_stall_valid", w ? d_rvalid : i_rvalid, 1);
        cyc();
      end
      set_rready(w, 1);
      #1;
      chk("r_valid", w ? d_rvalid : i_rvalid, 1);
      chk("r_other_valid", w ? i_rvalid : d_rvalid, 0);
      chk("r_data", w ? d_rdata : i_rdata, dat);
      chk("r_resp", w ? d_rresp : i_rresp, rsp);
      chk("r_last", w ? d_rlast : i_rlast, b == n_total - 1);
      chk("r_rready", m_rready, 1);
      chk("r_arvalid", m_arvalid, 0);
      chk("r_i_arready", i_arready, 0);
      chk("r_d_arready", d_arready, 0);
      cyc();
    end
    m_rvalid = 0; m_rlast = 0; i_rready = 0; d_rready = 0;
  endtask

  task automatic aw_phase(input logic [31:0] addr, input logic [3:0] len, input int delay);
    d_awvalid = 1; d_awaddr = addr; d_awlen = len; d_awsize = 3'd2; d_awburst = 2'b01;
    for (int c = 0; c <= delay; c++) begin
      m_awready = (c == delay);
      #1;
      chk("aw_valid", m_awvalid, 1);
      chk("aw_addr", m_awaddr, addr);
      chk("aw_id", m_awid, D_ID);
      chk("aw_len", m_awlen, len);
      chk("aw_ready", d_awready, c == delay);
      cyc();
    end
    d_awvalid = 0; m_awready = 0;
  endtask

  task automatic w_data(input int n);
    logic [31:0] dat;
    for (int b = 0; b < n; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        d_wvalid = 0;
        #1;
        chk("w_gap_valid", m_wvalid, 0);
        cyc();
      end
      dat = $urandom;
      d_wvalid = 1; d_wdata = dat; d_wstrb = 4'hF; d_wlast = (b == n - 1); m_wready = 1;
      #1;
      chk("w_valid", m_wvalid, 1);
      chk("w_data", m_wdata, dat);
      chk("w_strb", m_wstrb, 4'hF);
      chk("w_last", m_wlast, b == n - 1);
      chk("w_id", m_wid, D_ID);
      chk("w_ready", d_wready, 1);
      chk("w_aw_blocked", m_awvalid, 0);
      chk("w_awready_blocked", d_awready, 0);
      chk("w_bvalid", d_bvalid, 0);
      cyc();
    end
    d_wvalid = 0; d_wlast = 0; m_wready = 0;
  endtask

  // B phase; ends inside the first W_IDLE cycle without advancing the clock.
  task automatic w_resp();
    logic [1:0] rsp;
    int gap;
    gap = $urandom_range(0, 2);
    d_bready = 1; d_wvalid = 1; m_wready = 1;
    for (int c = 0; c < gap; c++) begin
      m_bvalid = 0;
      #1;
      chk("b_wait_bvalid", d_bvalid, 0);
      chk("b_wait_wvalid", m_wvalid, 0);
      chk("b_wait_awvalid", m_awvalid, 0);
      cyc();
    end
    rsp = 2'($urandom_range(0, 3));
    m_bvalid = 1; m_bresp = rsp;
    #1;
    chk("b_valid", d_bvalid, 1);
    chk("b_resp", d_bresp, rsp);
    chk("b_ready", m_bready, 1);
    chk("b_awvalid", m_awvalid, 0);
    cyc();
    d_wvalid = 0; m_wready = 0;
    #1;
    chk("b_once", d_bvalid, 0);
    m_bvalid = 0; d_bready = 0;
  endtask

  bit g;
  int ln;

  initial begin
    aresetn = 0;
    clear_inputs();
    cyc();
    cyc();
    aresetn = 1;
    #1;
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_m_awvalid", m_awvalid, 0);
    chk("rst_m_wvalid", m_wvalid, 0);
    chk("rst_m_rready", m_rready, 0);
    chk("rst_m_bready", m_bready, 0);
    chk("rst_i_arready", i_arready, 0);
    chk("rst_d_arready", d_arready, 0);
    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_d_awready", d_awready, 0);
    chk("rst_d_wready", d_wready, 0);
    chk("rst_d_bvalid", d_bvalid, 0);
    chk("const_lock", {m_arlock, m_awlock}, 0);
    chk("const_cache", {m_arcache, m_awcache}, 0);
    chk("const_prot", {m_arprot, m_awprot}, 0);
    cyc();

    // Simultaneous requests right after reset: dcache first, icache right after rlast.
    req(1, $urandom, 4'd7, 3'd2);
    req(0, 32'hBFC0_0000, 4'd7, 3'd2);
    ar_phase(0, -1, 0, g);
    r_beats(g, 8, 8);
    ar_phase(0, -1, 0, g);
    r_beats(g, 8, 8);

    // Dcache-only read with slave arready after 2 cycles.
    req(1, 32'h1FC0_0100, 4'd7, 3'd2);
    ar_phase(2, -1, 0, g);
    r_beats(g, 8, 8);

    // Locked grant: icache held off 3 cycles, dcache raised in the second cycle.
    req(0, $urandom, 4'd7, 3'd2);
    ar_phase(3, 1, $urandom, g);
    r_beats(g, 8, 8);
    ar_phase(0, -1, 0, g);
    r_beats(g, 8, 8);

    // Dcache write burst overlapped with an icache read; second AW waits for B.
    fork
      begin
        aw_phase($urandom, 4'd7, $urandom_range(0, 2));
        d_awvalid = 1; d_awaddr = 32'h0000_2000; m_awready = 1;
        w_data(8);
        w_resp();
        aw_phase(32'h0000_2000, 4'd0, 0);
        w_data(1);
        w_resp();
      end
      begin
        req(0, $urandom, 4'd7, 3'd2);
        ar_phase($urandom_range(0, 2), -1, 0, g);
        r_beats(g, 8, 8);
      end
    join
    cyc();

    // Uncached single-beat read, then icache granted with no idle cycle.
    req(1, $urandom, 4'd0, 3'd0);
    ar_phase(0, -1, 0, g);
    req(0, $urandom, 4'd7, 3'd2);
    r_beats(g, 1, 1);
    ar_phase(0, -1, 0, g);
    r_beats(g, 8, 8);

    // Random traffic against the round-robin model.
    for (int k = 0; k < 24; k++) begin
      if (!pend[0] && $urandom_range(0, 1) == 1) req(0, $urandom, 4'($urandom_range(0, 7)), 3'd2);
      if (!pend[1] && ($urandom_range(0, 1) == 1 || !pend[0])) req(1, $urandom, 4'($urandom_range(0, 7)), 3'd2);
      ar_phase($urandom_range(0, 2), -1, 0, g);
      ln = int'(pend_len[g]) + 1;
      r_beats(g, ln, ln);
    end

    // Both masters requesting continuously.
    for (int k = 0; k < 6; k++) begin
      if (!pend[0]) req(0, $urandom, 4'($urandom_range(0, 3)), 3'd2);
      if (!pend[1]) req(1, $urandom, 4'($urandom_range(0, 3)), 3'd2);
      ar_phase(0, -1, 0, g);
      ln = int'(pend_len[g]) + 1;
      r_beats(g, ln, ln);
    end
    if (pend[0]) begin
      ar_phase(0, -1, 0, g);
      ln = int'(pend_len[g]) + 1;
      r_beats(g, ln, ln);
    end
    if (pend[1]) begin
      ar_phase(0, -1, 0, g);
      ln = int'(pend_len[g]) + 1;
      r_beats(g, ln, ln);
    end

    // Reset dropped during the 4th R beat of an icache burst.
    req(0, $urandom, 4'd7, 3'd2);
    ar_phase(0, -1, 0, g);
    r_beats(g, 8, 3);
    m_rvalid = 1; m_rdata = $urandom; m_rlast = 0; i_rready = 1;
    #1;
    chk("pre_rst_i_rvalid", i_rvalid, 1);
    aresetn = 0;
    #1;
    chk("mid_rst_i_rvalid", i_rvalid, 0);
    chk("mid_rst_d_rvalid", d_rvalid, 0);
    chk("mid_rst_m_rready", m_rready, 0);
    clear_inputs();
    cyc();
    cyc();
    aresetn = 1;
    req(0, $urandom, 4'd3, 3'd2);
    req(1, $urandom, 4'd3, 3'd2);
    ar_phase(1, -1, 0, g);
    r_beats(g, 4, 4);
    ar_phase(0, -1, 0, g);
    r_beats(g, 4, 4);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/axi_master_arbiter.md
# axi_master_arbiter

Merges the instruction-cache AXI3 master and the data-cache AXI3 master (the `dcache_axi` bridge) into the single CPU AXI3 master port. Sits directly downstream of both cache bridges and upstream of the SoC crossbar. The read channel is arbitrated round-robin with at most one outstanding read burst. The write channel belongs to the data cache only, and is passed through with transaction tracking.

## Interface
Parameters:
- `I_ID`, 4'h0: ARID driven for instruction-cache reads.
- `D_ID`, 4'h1: ARID/AWID/WID driven for data-cache transactions.

Ports (name, direction, width, meaning):
- `aclk`, in, 1: the single clock.
- `aresetn`, in, 1: asynchronous, active-low reset.
- `i_araddr`/`i_arlen`/`i_arsize`/`i_arburst`/`i_arvalid`, in, 32/4/3/2/1: instruction-cache AR channel.
- `i_arready`, out, 1: AR ready to the instruction cache.
- `i_rdata`/`i_rresp`/`i_rlast`/`i_rvalid`, out, 32/2/1/1: R channel to the instruction cache.
- `i_rready`, in, 1: R ready from the instruction cache.
- `d_araddr`/`d_arlen`/`d_arsize`/`d_arburst`/`d_arvalid`, in, 32/4/3/2/1: data-cache AR channel.
- `d_arready`, out, 1: AR ready to the data cache.
- `d_rdata`/`d_rresp`/`d_rlast`/`d_rvalid`, out, 32/2/1/1: R channel to the data cache.
- `d_rready`, in, 1: R ready from the data cache.
- `d_awaddr`/`d_awlen`/`d_awsize`/`d_awburst`/`d_awvalid`, in, 32/4/3/2/1: data-cache AW channel.
- `d_awready`, out, 1: AW ready to the data cache.
- `d_wdata`/`d_wstrb`/`d_wlast`/`d_wvalid`, in, 32/4/1/1: data-cache W channel.
- `d_wready`, out, 1: W ready to the data cache.
- `d_bresp`/`d_bvalid`, out, 2/1: B channel to the data cache.
- `d_bready`, in, 1: B ready from the data cache.
- `m_ar*`, `m_r*`, `m_aw*`, `m_w*`, `m_b*`: full AXI3 master port. Outputs are `arid`, `araddr`, `arlen`, `arsize`, `arburst`, `arvalid`, `rready`, `awid`, `awaddr`, `awlen`, `awsize`, `awburst`, `awvalid`, `wid`, `wdata`, `wstrb`, `wlast`, `wvalid`, `bready`. Inputs are `arready`, `rid`, `rdata`, `rresp`, `rlast`, `rvalid`, `awready`, `wready`, `bid`, `bresp`, `bvalid`.
- Constant outputs: `m_arlock`/`m_awlock` = 0, `m_arcache`/`m_awcache` = 0, `m_arprot`/`m_awprot` = 0.

## Operation
Read FSM states: R_IDLE, R_ADDR_I, R_ADDR_D, R_DATA_I, R_DATA_D. A `last_grant` flag records the master granted most recently.
- R_IDLE selects a master combinationally:
  - only one master has `arvalid` → that master;
  - both assert `arvalid` → the master not equal to `last_grant`.
- The selected master's AR fields are forwarded to `m_ar*`, with `m_arid` set to `I_ID` or `D_ID`. `m_arready` is returned only to the selected master; the other master sees `arready` = 0.
- R_IDLE exits:
  - AR handshake in the same cycle → R_DATA_x, and `last_grant` ← x;
  - `arvalid` held but no handshake → R_ADDR_x. The grant is locked, and the other master cannot steal it even if the locked master drops `arvalid`.
- R_ADDR_x: forwards master x only. On handshake → R_DATA_x and `last_grant` ← x.
- R_DATA_x:
  - `m_arvalid` = 0 and both `arready` = 0;
  - `m_r*` is routed to master x, and `m_rready` = x's `rready`;
  - the other master's `rvalid` = 0.
  - `m_rvalid & m_rready & m_rlast` → R_IDLE.
- `m_rid` is ignored for routing, because only one read is outstanding at a time.

Write FSM states: W_IDLE, W_DATA, W_RESP.
- AW, W and B are wired straight through between `d_aw*/d_w*/d_b*` and `m_aw*/m_w*/m_b*`, with `m_awid` = `m_wid` = `D_ID`.
- Transitions:
  - W_IDLE → W_DATA on AW handshake;
  - W_DATA → W_RESP on `wvalid & wready & wlast`;
  - W_RESP → W_IDLE on `bvalid & bready`.
- Gating by state:
  - `m_awvalid` is forced to 0 outside W_IDLE (a single outstanding write);
  - `m_wvalid` passes only in W_IDLE or W_DATA;
  - `d_bvalid` passes only in W_RESP.
- Reads and writes proceed concurrently and independently.

## Timing
- Reset (`aresetn` low, asynchronous): read FSM → R_IDLE, write FSM → W_IDLE, `last_grant` ← I, so the data cache wins the first tie.
- With upstream valids low, every valid/ready output is 0. All data and address outputs are pure pass-through combinational logic.
- Zero added latency: AR, R, AW, W and B pass in the same cycle they arrive. There are no registers on the datapath.
- Back-to-back reads: the cycle after the final R beat (rlast), R_IDLE may grant and complete a new AR.
- Both masters requesting continuously alternate grants: D, I, D, I, …
- Reset asserted mid-burst: both FSMs return to their idle states immediately, and no further beats are routed. Upstream and downstream agents are reset together.
- AXI rule: no `valid` output depends on a `ready` input.

## Test plan
- Data-cache read only: `d_araddr`=0x1FC0_0100, `arlen`=7, slave `arready` after 2 cycles → `m_arid`=1, `d_arready` pulses once, 8 beats reach `d_r*`, `i_rvalid` stays 0, FSM returns to R_IDLE after beat 8.
- Simultaneous requests in the first cycle after reset → the data cache is granted first. The instruction-cache read (`arlen`=7, 0xBFC0_0000) is granted on the cycle after the data cache's rlast, with `m_arid`=0.
- Locked grant: `i_arvalid` with `m_arready`=0 for 3 cycles, `d_arvalid` raised in cycle 2 → `m_araddr` stays the instruction-cache address until its handshake.
- Data-cache write burst (`awlen`=7, `wstrb`=0xF) overlapped with an instruction-cache read → both complete. `d_bvalid` is seen once, and the second `d_awvalid` is blocked (`m_awvalid`=0) until B completes.
- Uncached single read (`arlen`=0, `arsize`=0) followed immediately by an instruction-cache read → 1 beat, then grant switches with 0 idle cycles.
- `aresetn` dropped during the 4th R beat → `i_rvalid`/`d_rvalid` fall to 0 in that cycle. After release, the first request is served normally.
